rf_wb: RTL and testbench

Write-back controller that drives the write side of the 4-entry, 8-bit register file: it owns the shared `data_in` bus and the `ce0`..`ce3` chip enables. It accepts register writes from the execute stage over a valid/ready handshake and buffers them in a small FIFO. It retires at most one write per cycle and forwards pending values to the read port so readers never see stale data. After reset it runs an init sequence that loads every register with a known value.

---
 rtl/rf_wb.sv | 139 +++++++++++++
 tb/tb_rf_wb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb.sv
// Write-back controller for a 4 x 8 register file: buffers execute-stage writes,
// retires one per cycle through registered enables, and forwards pending values.
module rf_wb #(
    parameter int          DEPTH    = 2,
    parameter logic [7:0]  INIT_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       rf_hold,
    output logic [7:0] data_in,
    output logic       ce0,
    output logic       ce1,
    output logic       ce2,
    output logic       ce3,
    input  logic [1:0] rd_addr,
    input  logic [7:0] rf_data,
    output logic [7:0] rd_data,
    output logic       rd_hit,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [3:0]    ce_q, ce_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    mem_addr_q [DEPTH];
    logic [7:0]    mem_data_q [DEPTH];

    logic          push, pop;
    logic [AW-1:0] fwd_idx;

    assign wr_ready = (state_q == S_RUN) && (count_q < (AW+1)'(DEPTH));
    assign push     = wr_valid && wr_ready;
    assign pop      = (state_q == S_RUN) && (count_q != '0) && !rf_hold;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ce_d    = '0;
        data_d  = data_q;
        case (state_q)
            S_INIT: begin
                if (!rf_hold) begin
                    ce_d[ptr_q] = 1'b1;
                    data_d      = INIT_VAL;
                    ptr_d       = ptr_q + 2'd1;
                    if (ptr_q == 2'd3) state_d = S_RUN;
                end
            end
            default: begin
                if (pop) begin
                    ce_d[mem_addr_q[head_q]] = 1'b1;
                    data_d = mem_data_q[head_q];
                    head_d = head_q + 1'b1;
                end
                if (push) tail_d = tail_q + 1'b1;
                case ({push, pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ce_q    <= '0;
            data_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ce_q    <= ce_d;
            data_q  <= data_d;
            if (push) begin
                mem_addr_q[tail_q] <= wr_addr;
                mem_data_q[tail_q] <= wr_data;
            end
        end
    end

    // Walk the FIFO oldest to youngest so the youngest match overrides; the
    // driver register sits below every queued entry in priority.
    always_comb begin
        rd_data = rf_data;
        rd_hit  = 1'b0;
        fwd_idx = head_q;
        if (state_q == S_INIT) begin
            rd_data = INIT_VAL;
            rd_hit  = 1'b1;
        end else begin
            if (ce_q[rd_addr]) begin
                rd_data = data_q;
                rd_hit  = 1'b1;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fwd_idx = head_q + AW'(i);
                if (((AW+1)'(i) < count_q) && (mem_addr_q[fwd_idx] == rd_addr)) begin
                    rd_data = mem_data_q[fwd_idx];
                    rd_hit  = 1'b1;
                end
            end
        end
    end

    assign busy    = (state_q == S_INIT) || (count_q != '0) || (ce_q != '0);
    assign data_in = data_q;
    assign ce0     = ce_q[0];
    assign ce1     = ce_q[1];
    assign ce2     = ce_q[2];
    assign ce3     = ce_q[3];

endmodule

// File: tb/tb_rf_wb.sv
// Randomized self-checking bench for rf_wb against a queue-based model of the
// write-back rules; the bench also plays the role of the register file.
module tb_rf_wb;

    localparam int         DEPTH = 2;
    localparam logic [7:0] IVAL  = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid, wr_ready;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       rf_hold;
    logic [7:0] data_in;
    logic       ce0, ce1, ce2, ce3;
    logic [1:0] rd_addr;
    logic [7:0] rf_data;
    logic [7:0] rd_data;
    logic       rd_hit;
    logic       busy;

    rf_wb #(.DEPTH(DEPTH), .INIT_VAL(IVAL)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rf_hold(rf_hold),
        .data_in(data_in),
        .ce0(ce0), .ce1(ce1), .ce2(ce2), .ce3(ce3),
        .rd_addr(rd_addr), .rf_data(rf_data),
        .rd_data(rd_data), .rd_hit(rd_hit),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file: captures data_in on the edge after a chip enable is seen.
    logic [7:0] rf_mem [4];
    always @(posedge clk) begin
        if (ce0) rf_mem[0] <= data_in;
        if (ce1) rf_mem[1] <= data_in;
        if (ce2) rf_mem[2] <= data_in;
        if (ce3) rf_mem[3] <= data_in;
    end
    assign rf_data = rf_mem[rd_addr];

    typedef struct packed {
        logic [1:0] a;
        logic [7:0] d;
    } ent_t;

    ent_t       q[$];
    bit         m_init;
    int         m_ptr;
    logic [3:0] m_ce;
    logic [7:0] m_data;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_init = 1'b1;
        m_ptr  = 0;
        m_ce   = 4'b0;
        m_data = 8'h00;
    endtask

    task automatic check_outputs();
        logic       e_ready;
        logic [7:0] e_rd;
        logic       e_hit;
        bit         found;
        e_ready = !m_init && (q.size() < DEPTH);
        found   = 1'b0;
        e_rd    = rf_mem[rd_addr];
        e_hit   = 1'b0;
        if (m_init) begin
            e_rd  = IVAL;
            e_hit = 1'b1;
        end else begin
            for (int i = q.size() - 1; i >= 0 && !found; i--) begin
                if (q[i].a == rd_addr) begin
                    e_rd  = q[i].d;
                    e_hit = 1'b1;
                    found = 1'b1;
                end
            end
            if (!found && m_ce[rd_addr]) begin
                e_rd  = m_data;
                e_hit = 1'b1;
            end
        end
        check("ce", {28'd0, ce3, ce2, ce1, ce0}, {28'd0, m_ce});
        check("data_in", {24'd0, data_in}, {24'd0, m_data});
        check("wr_ready", {31'd0, wr_ready}, {31'd0, e_ready});
        check("busy", {31'd0, busy}, {31'd0, (m_init || q.size() > 0 || m_ce != 4'b0)});
        check("rd_hit", {31'd0, rd_hit}, {31'd0, e_hit});
        check("rd_data", {24'd0, rd_data}, {24'd0, e_rd});
    endtask

    // One cycle: drive inputs in the low phase, check, then advance the model
    // to what the next rising edge should produce.
    task automatic step(input logic v, input logic [1:0] a, input logic [7:0] d,
                        input logic h, input logic [1:0] ra);
        logic e_ready;
        ent_t e;
        @(negedge clk);
        wr_valid = v; wr_addr = a; wr_data = d; rf_hold = h; rd_addr = ra;
        #1;
        check_outputs();
        e_ready = !m_init && (q.size() < DEPTH);
        if (m_init) begin
            if (!h) begin
                m_ce   = 4'b1 << m_ptr;
                m_data = IVAL;
                if (m_ptr == 3) m_init = 1'b0;
                m_ptr  = (m_ptr + 1) % 4;
            end else begin
                m_ce = 4'b0;
            end
        end else begin
            if (q.size() > 0 && !h) begin
                e      = q.pop_front();
                m_ce   = 4'b1 << e.a;
                m_data = e.d;
            end else begin
                m_ce = 4'b0;
            end
            if (v && e_ready) q.push_back('{a: a, d: d});
        end
    endtask

    // Asynchronous reset taken in the current low phase; released just after
    // a rising edge so the following low phase is cycle 0.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wr_valid = 1'b0; wr_addr = 2'd0; wr_data = 8'h00; rf_hold = 1'b0; rd_addr = 2'd0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Init sequence, then idle into RUN.
        for (int i = 0; i < 7; i++) step(1'b0, 2'd0, 8'h00, 1'b0, 2'(i));

        // Single write to reg 2, watched through the read port.
        step(1'b1, 2'd2, 8'h3C, 1'b0, 2'd2);
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 8'h00, 1'b0, 2'd2);

        // Back-pressure under hold, then release.
        step(1'b1, 2'd0, 8'h01, 1'b1, 2'd0);
        step(1'b1, 2'd1, 8'h02, 1'b1, 2'd0);
        step(1'b1, 2'd3, 8'h03, 1'b1, 2'd3);
        step(1'b1, 2'd3, 8'h03, 1'b0, 2'd3);
        step(1'b1, 2'd3, 8'h03, 1'b0, 2'd3);
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 8'h00, 1'b0, 2'd3);

        // Youngest FIFO entry wins for the same address.
        step(1'b1, 2'd1, 8'h11, 1'b1, 2'd1);
        step(1'b1, 2'd1, 8'h22, 1'b1, 2'd1);
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 8'h00, 1'b0, 2'd1);

        // Reset with two queued entries and ce3 in flight.
        step(1'b1, 2'd3, 8'h33, 1'b1, 2'd3);
        step(1'b1, 2'd0, 8'h44, 1'b1, 2'd0);
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd3);
        step(1'b1, 2'd1, 8'h55, 1'b1, 2'd1);
        check("ce3_before_rst", {31'd0, ce3}, 32'd1);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 8'h00, 1'b0, 2'(i));

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                 ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
